rx_buf_writer: RTL and testbench
================================

# rx_buf_writer

Write-side sequencer for the receiver sample buffer. On each decimated sample strobe it walks all receiver channels, packs each 24-bit I/Q pair into three 16-bit words and writes them into port A of the dual-port RX buffer BRAM. Samples are grouped into fixed-size blocks in a ring of NBLK blocks. The CPU consumes blocks via the read port and acknowledges them; the block reports block completion and overrun.

## Interface
Parameters:
- V_RX_CHANS, 4, number of receiver channels serviced per sample strobe
- CH_BITS, 2, width of channel select; must satisfy 2^CH_BITS ≥ V_RX_CHANS
- NRX_SAMPS, 84, sample sets per block
- NBLK, 8, blocks in the ring
- ADDR_MSB, 12, buffer address MSB, matching the RX buffer instance

Ports:
- adc_clk  in  1  sole clock; buffer port A runs on the same clock
- reset  in  1  synchronous, active-high
- rx_avail  in  1  one-cycle strobe: new sample set ready on all channels
- rx_sel  out  CH_BITS  channel select driven to the sample mux
- rx_iq  in  48  {I[23:0],Q[23:0]} of channel rx_sel, combinationally valid in the same cycle
- ticks  in  48  free-running timestamp; used only with RX_TSTAMP_EN
- wr_en  out  1  buffer port A write enable
- wr_addr  out  ADDR_MSB+1  buffer port A address
- wr_data  out  16  buffer port A data
- blk_done  out  1  one-cycle pulse when a block's final word is written
- blk_idx  out  log2(NBLK)  index of the block just completed; valid with blk_done and held until the next one
- blk_ack  in  1  one-cycle pulse: CPU has consumed the oldest pending block
- pend_cnt  out  log2(NBLK)+1  number of completed, unacknowledged blocks
- overrun  out  1  sticky flag: a sample set was lost
- ovfl_clr  in  1  clears overrun

## Operation
- Block size: BLK_WORDS = 3·V_RX_CHANS·NRX_SAMPS, plus 3 with RX_TSTAMP_EN. Block base = wblk·BLK_WORDS. NBLK·BLK_WORDS > 2^(ADDR_MSB+1) is an elaboration error ($error).
- FSM states: IDLE, W0, W1, W2, T0, T1, T2.
- IDLE: on rx_avail go to W0 with ch=0, unless the drop condition applies.
- W0: latch rx_iq and write I[23:8]. W1: write Q[23:8]. W2: write {I[7:0],Q[7:0]}. rx_sel=ch is held through W0–W2.
- After W2: if ch < V_RX_CHANS−1, increment ch and go to W0. Otherwise increment samp_cnt and return to IDLE.
- When samp_cnt reaches NRX_SAMPS: go to T0 (with RX_TSTAMP_EN), otherwise end the block directly.
- End of block: blk_done pulse, blk_idx=wblk, pend_cnt+1. wblk wraps NBLK−1→0. samp_cnt and the word offset clear.
- Drop condition: rx_avail while not IDLE, or rx_avail in IDLE with samp_cnt=0 and pend_cnt=NBLK. The set is discarded with no writes and overrun is set.
- blk_ack with pend_cnt=0 is ignored. blk_ack coincident with blk_done leaves pend_cnt unchanged.
- ovfl_clr and a new overrun event in the same cycle: overrun stays 1.
- rx_sel is 0 in IDLE.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, rx_sel=0, blk_done=0, blk_idx=0, pend_cnt=0, overrun=0. Internal state: IDLE, wblk=0, samp_cnt=0.
- Reset mid-block abandons the partial block; no blk_done is issued.
- wr_en, wr_addr and wr_data are registered: each write appears the cycle after its state. The first write follows rx_avail by 2 cycles.
- A sample set occupies 3·V_RX_CHANS consecutive write cycles, plus 3 for the timestamp on the last set of a block. Required rx_avail spacing: at least 3·V_RX_CHANS+5 cycles.
- Addresses within a block are strictly sequential.
- blk_done asserts in the cycle after the block's last wr_en. pend_cnt updates in that same cycle.

## Configuration
- RX_TSTAMP_EN defined: after the last sample set of each block, T0/T1/T2 write ticks[47:32], ticks[31:16], ticks[15:0]. ticks is latched at that block's final rx_avail. BLK_WORDS includes the +3.
- RX_TSTAMP_EN undefined: the T states and the ticks port logic are removed. ticks is ignored and BLK_WORDS has no +3.

## Test plan
- Single set, V_RX_CHANS=4, ch k rx_iq={24'hA0000k,24'hB0000k}. Required: 12 writes at addr 0..11; ch0 words 16'hA000, 16'hB000, 16'h0000; ch3 words 16'hA000, 16'hB000, 16'h0303.
- NRX_SAMPS=2, NBLK=2, no acks, 6 strobes:
  - blk_done pulses after strobes 2 and 4, with blk_idx 0 then 1; pend_cnt reaches 2.
  - Strobes 5–6 produce no writes; overrun=1.
  - After one blk_ack, strobe 7 writes at base 0.
- rx_avail reasserted 3 cycles after a prior strobe: second set dropped, overrun=1, first set's 12 writes intact.
- blk_ack coincident with blk_done at pend_cnt=1: pend_cnt stays 1. blk_ack at pend_cnt=0: stays 0.
- reset asserted after the 5th write of a set: outputs return to reset values; the next strobe writes at addr 0; no blk_done.
- RX_TSTAMP_EN defined, ticks=48'h123456789ABC at the block's final strobe: the last three words are 16'h1234, 16'h5678, 16'h9ABC, then blk_done.

Source files
------------

// File: rtl/rx_buf_writer.sv
// rx_buf_writer: write-side sequencer for the receiver sample buffer.
// On every accepted rx_avail strobe each channel's 24-bit I/Q pair is packed
// into three 16-bit words and written sequentially into buffer port A.
// Sample sets are grouped into blocks held in a ring of NBLK blocks. The CPU
// drains blocks and acknowledges them with blk_ack.
// Optional feature macro: RX_TSTAMP_EN appends three 16-bit timestamp words
// (ticks latched at the block's final strobe) to the end of every block.
module rx_buf_writer #(
    parameter int V_RX_CHANS = 4,
    parameter int CH_BITS    = 2,
    parameter int NRX_SAMPS  = 84,
    parameter int NBLK       = 8,
    parameter int ADDR_MSB   = 12
) (
    input  logic                    adc_clk,
    input  logic                    reset,
    input  logic                    rx_avail,
    output logic [CH_BITS-1:0]      rx_sel,
    input  logic [47:0]             rx_iq,
    input  logic [47:0]             ticks,
    output logic                    wr_en,
    output logic [ADDR_MSB:0]       wr_addr,
    output logic [15:0]             wr_data,
    output logic                    blk_done,
    output logic [$clog2(NBLK)-1:0] blk_idx,
    input  logic                    blk_ack,
    output logic [$clog2(NBLK):0]   pend_cnt,
    output logic                    overrun,
    input  logic                    ovfl_clr
);

`ifdef RX_TSTAMP_EN
    localparam int TS_WORDS = 3;
`else
    localparam int TS_WORDS = 0;
`endif

    localparam int BLK_WORDS = 3 * V_RX_CHANS * NRX_SAMPS + TS_WORDS;
    localparam int AW        = ADDR_MSB + 1;
    localparam int BW        = $clog2(NBLK);
    localparam int PW        = BW + 1;
    localparam int SC_W      = $clog2(NRX_SAMPS + 1);

    localparam logic [CH_BITS-1:0] LAST_CH   = CH_BITS'(V_RX_CHANS - 1);
    localparam logic [SC_W-1:0]    LAST_SAMP = SC_W'(NRX_SAMPS - 1);
    localparam logic [BW-1:0]      LAST_BLK  = BW'(NBLK - 1);
    localparam logic [PW-1:0]      PEND_FULL = PW'(NBLK);

    // The ring of blocks must fit inside the buffer address space.
    if (NBLK * BLK_WORDS > (2 ** AW)) begin : g_bad_ring_size
        $error("rx_buf_writer: NBLK*BLK_WORDS exceeds the buffer address space");
    end

    // Channel select must be able to address every channel.
    if ((2 ** CH_BITS) < V_RX_CHANS) begin : g_bad_ch_bits
        $error("rx_buf_writer: CH_BITS too small for V_RX_CHANS");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_W1,
        S_W2
`ifdef RX_TSTAMP_EN
        ,
        S_T0,
        S_T1,
        S_T2
`endif
    } state_t;

    state_t              state;
    logic [CH_BITS-1:0]  ch;
    logic [SC_W-1:0]     samp_cnt;
    logic [BW-1:0]       wblk;
    logic [AW-1:0]       addr;
    logic [31:0]         iq_lo;
    logic                end_pend;
    logic                drop;
    logic                ack_ok;

`ifdef RX_TSTAMP_EN
    logic [47:0]         ticks_r;
`else
    logic                unused_ticks;
    assign unused_ticks = ^ticks;
`endif

    // Strobe semantics: rx_avail is a one-cycle valid with no ready. A strobe
    // is taken only in IDLE with no block end in flight and, at a block
    // boundary, only if a free block exists; otherwise the set is discarded
    // and overrun records the loss. blk_ack is likewise a one-cycle valid; an
    // ack sampled on the same edge that raises blk_done cancels the increment.
    assign drop   = rx_avail && ((state != S_IDLE) || end_pend ||
                                 ((samp_cnt == '0) && (pend_cnt == PEND_FULL)));
    assign ack_ok = blk_ack && (pend_cnt != '0);

    // The channel counter is the registered channel select.
    assign rx_sel = ch;

    // Main sequencer: packs samples into words, addresses the ring, ends blocks.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ch       <= '0;
            samp_cnt <= '0;
            wblk     <= '0;
            addr     <= '0;
            iq_lo    <= '0;
            end_pend <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            blk_done <= 1'b0;
            blk_idx  <= '0;
`ifdef RX_TSTAMP_EN
            ticks_r  <= '0;
`endif
        end else begin
            wr_en    <= 1'b0;
            blk_done <= 1'b0;
            end_pend <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (end_pend) begin
                        // Block end: one cycle after the block's last write.
                        blk_done <= 1'b1;
                        blk_idx  <= wblk;
                        if (wblk == LAST_BLK) begin
                            wblk <= '0;
                            addr <= '0;
                        end else begin
                            wblk <= wblk + BW'(1);
                        end
                    end else if (rx_avail && !drop) begin
                        state <= S_W0;
                        ch    <= '0;
`ifdef RX_TSTAMP_EN
                        ticks_r <= ticks;
`endif
                    end
                end
                S_W0: begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    addr    <= addr + AW'(1);
                    wr_data <= rx_iq[47:32];
                    iq_lo   <= rx_iq[31:0];
                    state   <= S_W1;
                end
                S_W1: begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    addr    <= addr + AW'(1);
                    wr_data <= iq_lo[23:8];
                    state   <= S_W2;
                end
                S_W2: begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    addr    <= addr + AW'(1);
                    wr_data <= {iq_lo[31:24], iq_lo[7:0]};
                    if (ch != LAST_CH) begin
                        ch    <= ch + CH_BITS'(1);
                        state <= S_W0;
                    end else begin
                        ch <= '0;
                        if (samp_cnt == LAST_SAMP) begin
                            samp_cnt <= '0;
`ifdef RX_TSTAMP_EN
                            state    <= S_T0;
`else
                            state    <= S_IDLE;
                            end_pend <= 1'b1;
`endif
                        end else begin
                            samp_cnt <= samp_cnt + SC_W'(1);
                            state    <= S_IDLE;
                        end
                    end
                end
`ifdef RX_TSTAMP_EN
                S_T0: begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    addr    <= addr + AW'(1);
                    wr_data <= ticks_r[47:32];
                    state   <= S_T1;
                end
                S_T1: begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    addr    <= addr + AW'(1);
                    wr_data <= ticks_r[31:16];
                    state   <= S_T2;
                end
                S_T2: begin
                    wr_en    <= 1'b1;
                    wr_addr  <= addr;
                    addr     <= addr + AW'(1);
                    wr_data  <= ticks_r[15:0];
                    state    <= S_IDLE;
                    end_pend <= 1'b1;
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Count of completed blocks not yet acknowledged by the CPU.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            pend_cnt <= '0;
        end else if (end_pend && !ack_ok) begin
            pend_cnt <= pend_cnt + PW'(1);
        end else if (!end_pend && ack_ok) begin
            pend_cnt <= pend_cnt - PW'(1);
        end
    end

    // Sticky lost-sample flag; a new loss wins over a simultaneous clear.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovfl_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_buf_writer.sv
// Testbench for rx_buf_writer: directed scenarios followed by randomized
// strobes, acks and clears, checked against a block-level reference model.
module tb_rx_buf_writer;

    localparam int V    = 4;
    localparam int CHB  = 2;
    localparam int NRX  = 2;
    localparam int NB   = 2;
    localparam int AM   = 12;
`ifdef RX_TSTAMP_EN
    localparam int TS   = 1;
`else
    localparam int TS   = 0;
`endif
    localparam int BLKW = 3 * V * NRX + 3 * TS;
    localparam int BW   = $clog2(NB);

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_avail = 1'b0;
    logic [CHB-1:0]    rx_sel;
    logic [47:0]       rx_iq;
    logic [47:0]       ticks = '0;
    logic              wr_en;
    logic [AM:0]       wr_addr;
    logic [15:0]       wr_data;
    logic              blk_done;
    logic [BW-1:0]     blk_idx;
    logic              blk_ack = 1'b0;
    logic [BW:0]       pend_cnt;
    logic              overrun;
    logic              ovfl_clr = 1'b0;

    logic [47:0]       iq_tab [0:V-1];
    assign rx_iq = iq_tab[rx_sel];

    always #5 clk = ~clk;

    rx_buf_writer #(
        .V_RX_CHANS(V), .CH_BITS(CHB), .NRX_SAMPS(NRX), .NBLK(NB), .ADDR_MSB(AM)
    ) dut (
        .adc_clk(clk), .reset(reset), .rx_avail(rx_avail), .rx_sel(rx_sel),
        .rx_iq(rx_iq), .ticks(ticks), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .blk_done(blk_done), .blk_idx(blk_idx),
        .blk_ack(blk_ack), .pend_cnt(pend_cnt), .overrun(overrun),
        .ovfl_clr(ovfl_clr)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int neg_n = 0;
    int last_wr_neg = 0;
    int wr_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_done_q[$];
    logic [15:0] log_data[$];
    logic [AM:0] log_addr[$];

    // reference model: ring position, pending blocks, overrun
    int m_wblk, m_samp, m_off, m_pend, m_last_idx;
    bit m_ovr;
    int last_acc, busy_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    always @(posedge clk) cyc_n++;

    // Monitor: every write and every block end is matched against the model.
    always @(negedge clk) begin
        neg_n++;
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            wr_cnt++;
            last_wr_neg = neg_n;
            check("wr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("wr_addr_data", {16'(wr_addr), wr_data}, exp_q.pop_front());
        end
        if (blk_done === 1'b1) begin
            check("done_expected", 32'(exp_done_q.size() != 0), 1);
            if (exp_done_q.size() != 0) begin
                check("blk_idx", 32'(blk_idx), exp_done_q.pop_front());
                check("done_latency", 32'(neg_n - last_wr_neg), 1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model and driver tasks ----------------
    task automatic model_reset();
        m_wblk = 0; m_samp = 0; m_off = 0; m_pend = 0; m_last_idx = 0; m_ovr = 0;
        last_acc = -1000; busy_len = 0;
        exp_q.delete();
        exp_done_q.delete();
    endtask

    task automatic push_word(input logic [15:0] d);
        exp_q.push_back({16'(m_wblk * BLKW + m_off), d});
        m_off++;
    endtask

    task automatic model_accept(input bit dirv, input logic [47:0] tk);
        bit fin;
        logic [47:0] v;
        fin = (m_samp == NRX - 1);
        for (int c = 0; c < V; c++) begin
            if (dirv) v = {24'hA00000 + 24'(c), 24'hB00000 + 24'(c)};
            else      v = {16'($urandom), 32'($urandom)};
            iq_tab[c] = v;
            push_word(v[47:32]);
            push_word(v[23:8]);
            push_word({v[31:24], v[7:0]});
        end
        if (fin) begin
            if (TS != 0) begin
                push_word(tk[47:32]);
                push_word(tk[31:16]);
                push_word(tk[15:0]);
            end
            exp_done_q.push_back(32'(m_wblk));
            m_pend++;
            m_last_idx = m_wblk;
            m_wblk = (m_wblk + 1) % NB;
            m_samp = 0;
            m_off = 0;
        end else begin
            m_samp++;
        end
        busy_len = 3 * V + (fin ? 3 * TS + 1 : 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input bit dirv, input bit clr, input logic [47:0] tk);
        int k;
        bit drop;
        k = cyc_n - last_acc;
        drop = (k <= busy_len) || (m_samp == 0 && m_pend == NB);
        if (!drop) begin
            model_accept(dirv, tk);
            last_acc = cyc_n;
        end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
        rx_avail = 1'b1;
        ovfl_clr = clr;
        ticks = tk;
        @(posedge clk);
        #1;
        rx_avail = 1'b0;
        ovfl_clr = 1'b0;
    endtask

    task automatic ack();
        blk_ack = 1'b1;
        if (m_pend > 0) m_pend--;
        @(posedge clk);
        #1;
        blk_ack = 1'b0;
    endtask

    task automatic clr_ovr();
        ovfl_clr = 1'b1;
        m_ovr = 0;
        @(posedge clk);
        #1;
        ovfl_clr = 1'b0;
    endtask

    task automatic quiet_check(input string tag);
        check({tag, "_pend"}, 32'(pend_cnt), 32'(m_pend));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        check({tag, "_idx"}, 32'(blk_idx), 32'(m_last_idx));
        check({tag, "_sel"}, 32'(rx_sel), 0);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_rx_sel"}, 32'(rx_sel), 0);
        check({tag, "_blk_done"}, 32'(blk_done), 0);
        check({tag, "_blk_idx"}, 32'(blk_idx), 0);
        check({tag, "_pend"}, 32'(pend_cnt), 0);
        check({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s;
        bit got;
        for (int c = 0; c < V; c++) iq_tab[c] = '0;
        model_reset();

        reset = 1'b1;
        idle(3);
        reset_check("rst0");
        reset = 1'b0;
        idle(2);

        // single set with the fixed channel pattern
        s = wr_cnt;
        strobe(1, 0, 48'h0);
        check("lat_no_wr_yet", 32'(wr_en), 0);
        idle(1);
        check("lat_first_wr", 32'(wr_en), 1);
        check("lat_first_addr", 32'(wr_addr), 0);
        idle(busy_len + 2);
        check("set1_count", 32'(wr_cnt - s), 12);
        check("set1_w0", 32'(log_data[s + 0]), 32'h0000A000);
        check("set1_w1", 32'(log_data[s + 1]), 32'h0000B000);
        check("set1_w2", 32'(log_data[s + 2]), 32'h00000000);
        check("set1_w9", 32'(log_data[s + 9]), 32'h0000A000);
        check("set1_w10", 32'(log_data[s + 10]), 32'h0000B000);
        check("set1_w11", 32'(log_data[s + 11]), 32'h00000303);
        check("set1_a11", 32'(log_addr[s + 11]), 11);

        // strobe 2 finishes block 0
        strobe(0, 0, 48'h123456789ABC);
        idle(busy_len + 2);
`ifdef RX_TSTAMP_EN
        check("ts_hi", 32'(log_data[log_data.size() - 3]), 32'h1234);
        check("ts_mid", 32'(log_data[log_data.size() - 2]), 32'h5678);
        check("ts_lo", 32'(log_data[log_data.size() - 1]), 32'h9ABC);
`endif
        quiet_check("blk0");

        // strobes 3-4 finish block 1, ring now full
        strobe(0, 0, 48'(($urandom)));
        idle(busy_len + 2);
        strobe(0, 0, 48'(($urandom)));
        idle(busy_len + 2);
        quiet_check("blk1");

        // strobes 5-6 must be discarded
        s = wr_cnt;
        strobe(0, 0, 48'h0);
        idle(20);
        strobe(0, 0, 48'h0);
        idle(20);
        check("full_no_wr", 32'(wr_cnt - s), 0);
        quiet_check("full");

        // one ack frees block 0; strobe 7 lands at base 0
        ack();
        idle(2);
        quiet_check("ack1");
        s = wr_cnt;
        strobe(0, 0, 48'(($urandom)));
        idle(busy_len + 2);
        check("s7_base", 32'(log_addr[s]), 0);

        // strobe 8 ends block 0 with an ack on the block-end edge
        strobe(0, 0, {16'($urandom), 32'($urandom)});
        got = 0;
        for (int i = 0; i < 60; i++) begin
            if (wr_en === 1'b1 && exp_q.size() == 1) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("coinc_align", 32'(got), 1);
        blk_ack = 1'b1;
        m_pend--;
        @(posedge clk);
        #1;
        blk_ack = 1'b0;
        check("coinc_done", 32'(blk_done), 1);
        check("coinc_pend", 32'(pend_cnt), 32'(m_pend));
        idle(3);
        quiet_check("coinc");
        ack();
        idle(1);
        check("ack_to_zero", 32'(pend_cnt), 32'(m_pend));
        ack();
        idle(1);
        check("ack_at_zero", 32'(pend_cnt), 0);

        // strobe 3 cycles after an accepted one is lost
        clr_ovr();
        check("ovr_cleared", 32'(overrun), 0);
        s = wr_cnt;
        strobe(0, 0, 48'h0);
        idle(2);
        strobe(0, 0, 48'h0);
        idle(busy_len + 2);
        check("close_count", 32'(wr_cnt - s), 12);
        check("close_ovr", 32'(overrun), 1);

        // loss and clear on the same edge: loss wins
        clr_ovr();
        strobe(0, 0, {16'($urandom), 32'($urandom)});
        idle(2);
        strobe(0, 1, 48'h0);
        idle(busy_len + 2);
        quiet_check("clr_vs_set");

        // reset in the middle of a set
        s = wr_cnt;
        strobe(0, 0, 48'h0);
        for (int i = 0; i < 40 && wr_cnt < s + 5; i++) idle(1);
        check("rst_reach5", 32'(wr_cnt >= s + 5), 1);
        reset = 1'b1;
        idle(1);
        reset_check("rst_mid");
        model_reset();
        idle(1);
        reset = 1'b0;
        idle(3);
        s = wr_cnt;
        strobe(0, 0, 48'h0);
        idle(busy_len + 2);
        check("post_rst_base", 32'(log_addr[s]), 0);
        check("post_rst_count", 32'(wr_cnt - s), 12);
        quiet_check("post_rst");

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            strobe(0, 0, {16'($urandom), 32'($urandom)});
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(0, busy_len - 2));
                strobe(0, 0, {16'($urandom), 32'($urandom)});
            end
            idle(busy_len + 2 + $urandom_range(0, 3));
            quiet_check("rnd");
            if ($urandom_range(0, 2) == 0) ack();
            if ($urandom_range(0, 4) == 0) clr_ovr();
        end
        idle(5);
        quiet_check("rnd_end");
        check("exp_q_drained", 32'(exp_q.size()), 0);
        check("done_q_drained", 32'(exp_done_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
